// File: rtl/grid_position_encoder.sv
// Grid cell to cursor position encoder: glides {x,y} one pixel per step tick toward the centre of a 3x3 cell.
// Optional GRID_ENC_RETARGET_EN: accept new requests while moving and retarget on the fly.
module grid_position_encoder #(
  parameter int STEP_DIV = 50000,
  parameter int X_C0     = 26,
  parameter int X_C1     = 80,
  parameter int X_C2     = 133,
  parameter int Y_C0     = 20,
  parameter int Y_C1     = 60,
  parameter int Y_C2     = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_col,
  input  logic [1:0]  req_row,
  output logic [15:0] pos_out,
  output logic        pos_update,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(STEP_DIV) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [7:0] X_RST = 8'(X_C1);
  localparam logic [7:0] Y_RST = 8'(Y_C1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [7:0]      x_r, y_r, tx_r, ty_r;
  logic [CW-1:0]   cnt_r;
  logic            step_r, pos_update_r, done_r, err_r;

  logic            accept_s, req_bad_s, at_tgt_s, tick_s;
  logic [7:0]      eff_tx_s, eff_ty_s, nx_s, ny_s;

  function automatic logic [7:0] centre_x(input logic [1:0] c);
    case (c)
      2'd0:    centre_x = 8'(X_C0);
      2'd1:    centre_x = 8'(X_C1);
      2'd2:    centre_x = 8'(X_C2);
      default: centre_x = 8'(X_C1);
    endcase
  endfunction

  function automatic logic [7:0] centre_y(input logic [1:0] r);
    case (r)
      2'd0:    centre_y = 8'(Y_C0);
      2'd1:    centre_y = 8'(Y_C1);
      2'd2:    centre_y = 8'(Y_C2);
      default: centre_y = 8'(Y_C1);
    endcase
  endfunction

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      step_toward = cur + 8'd1;
    end else if (cur > tgt) begin
      step_toward = cur - 8'd1;
    end else begin
      step_toward = cur;
    end
  endfunction

`ifdef GRID_ENC_RETARGET_EN
  assign req_ready = (state_r == ST_IDLE) || (state_r == ST_MOVE);
`else
  assign req_ready = (state_r == ST_IDLE);
`endif
  assign busy       = (state_r == ST_MOVE) || (state_r == ST_DONE);
  assign pos_out    = {x_r, y_r};
  assign pos_update = pos_update_r;
  assign done       = done_r;
  assign err        = err_r;

  // Request decode and the target the current MOVE cycle steers toward
  always_comb begin
    accept_s  = req_valid & req_ready;
    req_bad_s = (req_col == 2'd3) || (req_row == 2'd3);
    if (accept_s && !req_bad_s) begin
      eff_tx_s = centre_x(req_col);
      eff_ty_s = centre_y(req_row);
    end else begin
      eff_tx_s = tx_r;
      eff_ty_s = ty_r;
    end
    at_tgt_s = (x_r == eff_tx_s) && (y_r == eff_ty_s);
    tick_s   = (cnt_r == CNT_LAST);
    nx_s     = step_toward(x_r, eff_tx_s);
    ny_s     = step_toward(y_r, eff_ty_s);
  end

  // Control FSM, step counter, cursor position and output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      x_r          <= X_RST;
      y_r          <= Y_RST;
      tx_r         <= X_RST;
      ty_r         <= Y_RST;
      cnt_r        <= '0;
      step_r       <= 1'b0;
      pos_update_r <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      step_r       <= 1'b0;
      pos_update_r <= step_r;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (req_bad_s) begin
              err_r <= 1'b1;
            end else begin
              tx_r    <= eff_tx_s;
              ty_r    <= eff_ty_s;
              cnt_r   <= '0;
              state_r <= ST_MOVE;
            end
          end
        end
        ST_MOVE: begin
          // Retarget keeps the tick phase; only the target changes
          if (accept_s) begin
            if (req_bad_s) begin
              err_r <= 1'b1;
            end else begin
              tx_r <= eff_tx_s;
              ty_r <= eff_ty_s;
            end
          end
          if (at_tgt_s) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else if (tick_s) begin
            cnt_r  <= '0;
            x_r    <= nx_s;
            y_r    <= ny_s;
            step_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_position_encoder.sv
// Self-checking bench for grid_position_encoder (STEP_DIV=4): vector table, corner sequences, random requests.
module tb_grid_position_encoder;

  localparam int STEP = 4;
`ifdef GRID_ENC_RETARGET_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_col;
  logic [1:0]  req_row;
  logic [15:0] pos_out;
  logic        pos_update;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cur_x  = 80;
  int cur_y  = 60;

  grid_position_encoder #(.STEP_DIV(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_col(req_col), .req_row(req_row), .pos_out(pos_out), .pos_update(pos_update),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cx(input int c);
    return (c == 0) ? 26 : (c == 1) ? 80 : 133;
  endfunction

  function automatic int cy(input int r);
    return (r == 0) ? 20 : (r == 1) ? 60 : 100;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // axis position after n step ticks, moving from 'from' toward 'to'
  function automatic int axis_at(input int from, input int to, input int n);
    int d;
    d = iabs(to - from);
    if (n > d) n = d;
    return (to >= from) ? from + n : from - n;
  endfunction

  // Issues one request from idle and checks every cycle against the arithmetic model.
  // done_k = edge index (accept edge = 0) after which DONE was seen, -1 if never.
  task automatic run_req(input int c, input int r, input bit noise,
                         output int done_k, output int upd_cnt, output logic [15:0] pos_end);
    int tx, ty, m, ex, ey, kmax;
    bit bad;
    bad     = (c == 3) || (r == 3);
    done_k  = -1;
    upd_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_col   = 2'(c);
    req_row   = 2'(r);
    @(negedge clk);
    req_valid = 1'b0;
    if (bad) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_ready", 32'(req_ready), 32'd1);
      chk("err_pos", 32'(pos_out), 32'((cur_x << 8) | cur_y));
      @(negedge clk);
      chk("err_clear", 32'(err), 32'd0);
      chk("err_pos2", 32'(pos_out), 32'((cur_x << 8) | cur_y));
      pos_end = pos_out;
      return;
    end
    tx   = cx(c);
    ty   = cy(r);
    m    = (iabs(tx - cur_x) > iabs(ty - cur_y)) ? iabs(tx - cur_x) : iabs(ty - cur_y);
    kmax = STEP * m + 2;
    for (int k = 0; k <= kmax; k++) begin
      ex = axis_at(cur_x, tx, k / STEP);
      ey = axis_at(cur_y, ty, k / STEP);
      chk("pos", 32'(pos_out), 32'((ex << 8) | ey));
      chk("done", 32'(done), 32'(k == STEP * m + 1));
      chk("busy", 32'(busy), 32'(k <= STEP * m + 1));
      chk("ready", 32'(req_ready), 32'((k > STEP * m + 1) || (RT && k <= STEP * m)));
      chk("pos_update", 32'(pos_update),
          32'((k >= STEP + 1) && ((k - 1) % STEP == 0) && ((k - 1) / STEP <= m)));
      chk("no_err", 32'(err), 32'd0);
      if (done) done_k = k;
      if (pos_update) upd_cnt++;
      req_valid = noise && !RT && (k <= STEP * m) && ($urandom_range(0, 1) == 1);
      req_col   = 2'($urandom_range(0, 3));
      req_row   = 2'($urandom_range(0, 3));
      if (k < kmax) @(negedge clk);
    end
    req_valid = 1'b0;
    cur_x     = tx;
    cur_y     = ty;
    pos_end   = pos_out;
  endtask

  typedef struct {
    int          col;
    int          row;
    logic [15:0] exp_pos;
    int          exp_done_k;
    int          exp_upd;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int dk, uc, dcnt, timeout;
    logic [15:0] pe;

    tbl[0] = '{col: 0, row: 0, exp_pos: 16'h1A14, exp_done_k: 217, exp_upd: 54};
    tbl[1] = '{col: 0, row: 0, exp_pos: 16'h1A14, exp_done_k: 1,   exp_upd: 0};
    tbl[2] = '{col: 2, row: 2, exp_pos: 16'h8564, exp_done_k: 429, exp_upd: 107};
    tbl[3] = '{col: 3, row: 1, exp_pos: 16'h8564, exp_done_k: -1,  exp_upd: 0};
    tbl[4] = '{col: 1, row: 1, exp_pos: 16'h503C, exp_done_k: 213, exp_upd: 53};
    tbl[5] = '{col: 1, row: 3, exp_pos: 16'h503C, exp_done_k: -1,  exp_upd: 0};
    tbl[6] = '{col: 1, row: 1, exp_pos: 16'h503C, exp_done_k: 1,   exp_upd: 0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_col   = 2'd0;
    req_row   = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pos", 32'(pos_out), 32'h503C);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_upd", 32'(pos_update), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_req(tbl[i].col, tbl[i].row, 1'b0, dk, uc, pe);
      chk("vec_pos", 32'(pe), 32'(tbl[i].exp_pos));
      chk("vec_done_k", 32'(dk), 32'(tbl[i].exp_done_k));
      chk("vec_upd", 32'(uc), 32'(tbl[i].exp_upd));
    end

    // Reset in the middle of a move: position snaps back, no DONE follows
    @(negedge clk);
    req_valid = 1'b1; req_col = 2'd2; req_row = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_pos", 32'(pos_out), 32'h5A46);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pos", 32'(pos_out), 32'h503C);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("mid_rst_no_done", 32'(dcnt), 32'd0);
    chk("mid_rst_pos_hold", 32'(pos_out), 32'h503C);
    cur_x = 80; cur_y = 60;

    // Second request after five steps: retargets with the macro, ignored without
    @(negedge clk);
    req_valid = 1'b1; req_col = 2'd2; req_row = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("rt_pos5", 32'(pos_out), 32'h5541);
    chk("rt_ready", 32'(req_ready), 32'(RT));
    req_valid = 1'b1; req_col = 2'd0; req_row = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    dcnt = 0;
    timeout = 1;
    for (int i = 0; i < 2000; i++) begin
      if (done) dcnt++;
      if (!busy) begin
        timeout = 0;
        break;
      end
      @(negedge clk);
    end
    chk("rt_timeout", 32'(timeout), 32'd0);
    chk("rt_done_cnt", 32'(dcnt), 32'd1);
    chk("rt_end_pos", 32'(pos_out), RT ? 32'h1A3C : 32'h8564);
    cur_x = RT ? 26 : 133;
    cur_y = RT ? 60 : 100;

    // Random requests from wherever the cursor is, with ignored strobes mid-move
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, dk, uc, pe);
      chk("rnd_pos", 32'(pe), 32'((cur_x << 8) | cur_y));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
